servo_pwm_bank: RTL and testbench

//  Multi-channel servo PWM generator; parametrised successor to the single fixed-period refresh counter.
//  One shared frame counter with a runtime-programmable period drives CH pulse-width comparators.

---
 rtl/servo_pwm_bank_if.sv | 18 +
 rtl/servo_pwm_bank.sv | 149 ++++++++++++++
 tb/tb_servo_pwm_bank.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/servo_pwm_bank_if.sv
// Pulse-width write port of servo_pwm_bank.
//   wr_valid/wr_ready : request/accept handshake (accepted when both high)
//   wr_ch             : target channel index
//   wr_pw             : requested pulse width in clk cycles
//   wr_err            : 1-cycle pulse after an accepted write to a nonexistent channel
interface servo_pwm_bank_if #(
  parameter int CNT_W = 20,
  parameter int CH_W  = 2
);
  logic             wr_valid;
  logic             wr_ready;
  logic [CH_W-1:0]  wr_ch;
  logic [CNT_W-1:0] wr_pw;
  logic             wr_err;

  modport master (output wr_valid, wr_ch, wr_pw, input wr_ready, wr_err);
  modport slave  (input wr_valid, wr_ch, wr_pw, output wr_ready, wr_err);
endinterface

// File: rtl/servo_pwm_bank.sv
// Multi-channel servo PWM generator. A shared frame counter with a runtime
// period drives CH pulse-width comparators. Widths are double-buffered:
// writes land in a pending register and are committed at the frame boundary,
// so an output never changes width mid-frame.
// Optional feature: define SLEW_LIMIT_EN to limit each commit's change of an
// active width to SLEW_STEP; undefined, the pending width is copied directly.
// Ports:
//   clk, clr_n   clock, asynchronous active-low reset
//   en           run enable (0: counter held at 0, all pwm low)
//   period       requested frame length, sampled at the frame boundary
//   wr           pulse-width write port (servo_pwm_bank_if.slave)
//   pwm          registered servo outputs
//   count        current frame counter value
//   frame_start  1-cycle pulse on the cycle the counter wraps to 0

// Per-channel pending/active width and registered comparator.
module servo_pwm_ch #(
  parameter int CNT_W     = 20,
  parameter int RST_PW    = 150000,
  parameter int SLEW_STEP = 1000
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             en,
  input  logic             commit,
  input  logic             wr_hit,
  input  logic [CNT_W-1:0] wr_pw,
  input  logic [CNT_W-1:0] count_d,
  output logic             pwm
);
`ifdef SLEW_LIMIT_EN
  localparam bit SLEW_ON = 1'b1;
`else
  localparam bit SLEW_ON = 1'b0;
`endif
  // Without slew limiting the step is unbounded, so act lands exactly on pend.
  localparam logic [CNT_W-1:0] STEP_L = SLEW_ON ? CNT_W'(SLEW_STEP) : {CNT_W{1'b1}};

  logic [CNT_W-1:0] act_q, act_d, pend_q, pend_d, diff;
  logic             pwm_q, pwm_d;

  always_comb begin
    pend_d = wr_hit ? wr_pw : pend_q;
    diff   = (pend_q > act_q) ? pend_q - act_q : act_q - pend_q;
    if (diff > STEP_L) diff = STEP_L;
    act_d  = act_q;
    if (commit) act_d = (pend_q > act_q) ? act_q + diff : act_q - diff;
    // Compare against the next count so the registered output lines up
    // with the count shown in the same cycle.
    pwm_d  = en && (count_d < act_d);
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      act_q  <= CNT_W'(RST_PW);
      pend_q <= CNT_W'(RST_PW);
      pwm_q  <= 1'b0;
    end else begin
      act_q  <= act_d;
      pend_q <= pend_d;
      pwm_q  <= pwm_d;
    end
  end

  assign pwm = pwm_q;
endmodule

module servo_pwm_bank #(
  parameter int CH         = 4,
  parameter int CNT_W      = 20,
  parameter int PERIOD_DEF = 1000000,
  parameter int MIN_PW     = 100000,
  parameter int MAX_PW     = 200000,
  parameter int RST_PW     = 150000,
  parameter int SLEW_STEP  = 1000
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              en,
  input  logic [CNT_W-1:0]  period,
  servo_pwm_bank_if.slave   wr,
  output logic [CH-1:0]     pwm,
  output logic [CNT_W-1:0]  count,
  output logic              frame_start
);
  localparam int               CH_W   = (CH > 1) ? $clog2(CH) : 1;
  localparam logic [CH_W:0]    CH_LIM = (CH_W+1)'(CH);
  localparam logic [CNT_W-1:0] MIN_L  = CNT_W'(MIN_PW);
  localparam logic [CNT_W-1:0] MAX_L  = CNT_W'(MAX_PW);
  localparam logic [CNT_W-1:0] TWO_L  = CNT_W'(2);

  logic [CNT_W-1:0] count_q, count_d, period_q, period_d, pw_clamp;
  logic             frame_start_q, frame_start_d, wr_err_q, wr_err_d;
  logic             rdy_q, rdy_d;
  logic             commit, wr_fire, ch_ok;

  // Last cycle of an enabled frame; writes are refused here so a write can
  // never land in the same cycle its channel is committed.
  assign commit      = en && (count_q == period_q - CNT_W'(1));
  assign wr.wr_ready = rdy_q && !commit;
  assign wr_fire     = wr.wr_valid && wr.wr_ready;
  assign ch_ok       = {1'b0, wr.wr_ch} < CH_LIM;

  always_comb begin
    count_d = count_q + CNT_W'(1);
    if (!en || commit) count_d = '0;
    period_d = period_q;
    if (commit) period_d = (period < TWO_L) ? TWO_L : period;
    frame_start_d = commit;
    wr_err_d      = wr_fire && !ch_ok;
    rdy_d         = 1'b1;
    pw_clamp      = wr.wr_pw;
    if (wr.wr_pw < MIN_L)      pw_clamp = MIN_L;
    else if (wr.wr_pw > MAX_L) pw_clamp = MAX_L;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      count_q       <= '0;
      period_q      <= CNT_W'(PERIOD_DEF);
      frame_start_q <= 1'b0;
      wr_err_q      <= 1'b0;
      rdy_q         <= 1'b0;
    end else begin
      count_q       <= count_d;
      period_q      <= period_d;
      frame_start_q <= frame_start_d;
      wr_err_q      <= wr_err_d;
      rdy_q         <= rdy_d;
    end
  end

  for (genvar i = 0; i < CH; i++) begin : g_ch
    servo_pwm_ch #(.CNT_W(CNT_W), .RST_PW(RST_PW), .SLEW_STEP(SLEW_STEP)) u_ch (
      .clk     (clk),
      .clr_n   (clr_n),
      .en      (en),
      .commit  (commit),
      .wr_hit  (wr_fire && ch_ok && (wr.wr_ch == CH_W'(i))),
      .wr_pw   (pw_clamp),
      .count_d (count_d),
      .pwm     (pwm[i])
    );
  end

  assign count       = count_q;
  assign frame_start = frame_start_q;
  assign wr.wr_err   = wr_err_q;
endmodule

// File: tb/tb_servo_pwm_bank.sv
module tb_servo_pwm_bank;
  logic       clk = 1'b0;
  logic       clr_n, en;
  logic [7:0] period;
  logic [1:0] pwm;
  logic [7:0] count;
  logic       frame_start;
  logic [2:0] pwm3;
  logic [7:0] count3;
  logic       frame_start3;
  int checks = 0;
  int errors = 0;

  // Reference model of active widths (pending updated by the write task).
  logic [7:0] m_act [2];
  logic [7:0] m_pend[2];

  always #5 clk = ~clk;

  servo_pwm_bank_if #(.CNT_W(8), .CH_W(1)) wif();
  servo_pwm_bank_if #(.CNT_W(8), .CH_W(2)) wif3();

  servo_pwm_bank #(.CH(2), .CNT_W(8), .PERIOD_DEF(20), .MIN_PW(4), .MAX_PW(12),
                   .RST_PW(8), .SLEW_STEP(2)) dut (
    .clk(clk), .clr_n(clr_n), .en(en), .period(period), .wr(wif),
    .pwm(pwm), .count(count), .frame_start(frame_start));

  // Three-channel instance: lets a 2-bit wr_ch address a missing channel.
  servo_pwm_bank #(.CH(3), .CNT_W(8), .PERIOD_DEF(20), .MIN_PW(4), .MAX_PW(12),
                   .RST_PW(8), .SLEW_STEP(2)) dut3 (
    .clk(clk), .clr_n(clr_n), .en(en), .period(period), .wr(wif3),
    .pwm(pwm3), .count(count3), .frame_start(frame_start3));

  function automatic logic [7:0] clamp(input logic [7:0] pw);
    return (pw < 8'd4) ? 8'd4 : (pw > 8'd12) ? 8'd12 : pw;
  endfunction

  function automatic logic [7:0] step(input logic [7:0] a, input logic [7:0] p);
`ifdef SLEW_LIMIT_EN
    if (p > a) return (p - a > 8'd2) ? a + 8'd2 : p;
    else       return (a - p > 8'd2) ? a - 8'd2 : p;
`else
    return p;
`endif
  endfunction

  always @(negedge clk) begin
    if (!clr_n) begin
      m_act[0] <= 8'd8;
      m_act[1] <= 8'd8;
    end else if (frame_start === 1'b1) begin
      for (int i = 0; i < 2; i++) m_act[i] <= step(m_act[i], m_pend[i]);
    end
  end

  task automatic wait_count(input logic [7:0] v);
    int t = 0;
    while (count !== v && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) begin
      checks++; errors++;
      $display("FAIL wait_count: count=%0d never reached %0d", count, v);
    end
  endtask

  // Measures the next full frame: high cycles of pwm[ch], frame length,
  // and the model width in force for that frame. Returns on the next frame_start.
  task automatic measure(input int ch, output int hi, output int len, output int w);
    int t = 0;
    hi = 0; len = 0; w = 0;
    while (frame_start !== 1'b1 && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) begin
      checks++; errors++;
      $display("FAIL measure_start: no frame_start within 200 cycles");
      return;
    end
    #1 w = m_act[ch];
    t = 0;
    do begin
      len++;
      if (pwm[ch] === 1'b1) hi++;
      @(negedge clk); t++;
    end while (frame_start !== 1'b1 && t < 300);
    if (t >= 300) begin
      checks++; errors++;
      $display("FAIL measure_end: frame longer than 300 cycles");
    end
  endtask

  task automatic do_write(input logic ch, input logic [7:0] pw, output bit acc);
    wif.wr_valid = 1'b1; wif.wr_ch = ch; wif.wr_pw = pw;
    acc = wif.wr_ready;
    @(negedge clk);
    wif.wr_valid = 1'b0;
    if (acc) m_pend[ch] = clamp(pw);
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++; if (count !== 8'd0)     begin errors++; $display("FAIL rst_count: got %0d want 0", count); end
    checks++; if (pwm !== 2'b00)      begin errors++; $display("FAIL rst_pwm: got %b want 00", pwm); end
    checks++; if (frame_start !== 0)  begin errors++; $display("FAIL rst_fs: got %b want 0", frame_start); end
    checks++; if (wif.wr_ready !== 0) begin errors++; $display("FAIL rst_ready: got %b want 0", wif.wr_ready); end
    checks++; if (wif.wr_err !== 0)   begin errors++; $display("FAIL rst_err: got %b want 0", wif.wr_err); end
    clr_n = 1'b1; en = 1'b1;
    @(negedge clk);
    checks++; if (wif.wr_ready !== 1) begin errors++; $display("FAIL ready_after_rst: got %b want 1", wif.wr_ready); end
    wait_count(8'd13);
    #2 clr_n = 1'b0;
    #1;
    checks++; if (count !== 8'd0) begin errors++; $display("FAIL midframe_rst_count: got %0d want 0", count); end
    checks++; if (pwm !== 2'b00)  begin errors++; $display("FAIL midframe_rst_pwm: got %b want 00", pwm); end
    m_pend[0] = 8'd8; m_pend[1] = 8'd8;
    repeat (2) @(negedge clk);
    clr_n = 1'b1;
  endtask

  task automatic test_basic;
    int hi, len, w;
    measure(0, hi, len, w);
    checks++; if (len !== 20) begin errors++; $display("FAIL basic_len: got %0d want 20", len); end
    checks++; if (hi !== 8)   begin errors++; $display("FAIL basic_hi0: got %0d want 8", hi); end
    @(negedge clk);
    checks++; if (frame_start !== 0 || count !== 8'd1)
      begin errors++; $display("FAIL fs_pulse: got fs=%b count=%0d want fs=0 count=1", frame_start, count); end
    wait_count(8'd7);
    checks++; if (pwm[0] !== 1) begin errors++; $display("FAIL edge_7: got %b want 1", pwm[0]); end
    @(negedge clk);
    checks++; if (pwm[0] !== 0) begin errors++; $display("FAIL edge_8: got %b want 0", pwm[0]); end
    measure(1, hi, len, w);
    checks++; if (hi !== 8) begin errors++; $display("FAIL basic_hi1: got %0d want 8", hi); end
  endtask

  task automatic test_write_defer;
    int hi, len, w;
    bit acc;
    wait_count(8'd5);
    do_write(1'b1, 8'd10, acc);
    checks++; if (!acc) begin errors++; $display("FAIL defer_acc: got ready=0 want 1"); end
    wait_count(8'd9);
    checks++; if (pwm[1] !== 0) begin errors++; $display("FAIL defer_same_frame: got %b want 0", pwm[1]); end
    checks++; if (wif.wr_err !== 0) begin errors++; $display("FAIL defer_err: got %b want 0", wif.wr_err); end
    measure(1, hi, len, w);
    checks++; if (hi !== 10) begin errors++; $display("FAIL defer_next_frame: got %0d want 10", hi); end
  endtask

  task automatic test_clamp;
    int hi, len, w;
    bit acc;
    @(negedge clk);
    do_write(1'b0, 8'd2, acc);
    measure(0, hi, len, w);
    checks++; if (hi !== w) begin errors++; $display("FAIL clamp_lo: got %0d want %0d", hi, w); end
`ifndef SLEW_LIMIT_EN
    checks++; if (hi !== 4) begin errors++; $display("FAIL clamp_lo_abs: got %0d want 4", hi); end
`endif
    @(negedge clk);
    do_write(1'b0, 8'd30, acc);
    measure(0, hi, len, w);
    checks++; if (hi !== w) begin errors++; $display("FAIL clamp_hi: got %0d want %0d", hi, w); end
`ifndef SLEW_LIMIT_EN
    checks++; if (hi !== 12) begin errors++; $display("FAIL clamp_hi_abs: got %0d want 12", hi); end
`endif
    // Bad channel on the three-channel instance.
    @(negedge clk);
    wif3.wr_valid = 1'b1; wif3.wr_ch = 2'd3; wif3.wr_pw = 8'd5;
    acc = wif3.wr_ready;
    @(negedge clk);
    wif3.wr_valid = 1'b0;
    checks++; if (wif3.wr_err !== 1 || !acc)
      begin errors++; $display("FAIL err_pulse: got err=%b acc=%b want 1 1", wif3.wr_err, acc); end
    @(negedge clk);
    checks++; if (wif3.wr_err !== 0) begin errors++; $display("FAIL err_width: got %b want 0", wif3.wr_err); end
    wif3.wr_valid = 1'b1; wif3.wr_ch = 2'd2;
    @(negedge clk);
    wif3.wr_valid = 1'b0;
    checks++; if (wif3.wr_err !== 0) begin errors++; $display("FAIL err_valid_ch: got %b want 0", wif3.wr_err); end
  endtask

  task automatic test_ready_commit;
    int hi, len, w;
    logic exp_b;
    wait_count(8'd19);
    wif.wr_valid = 1'b1; wif.wr_ch = 1'b0; wif.wr_pw = 8'd6;
    checks++; if (wif.wr_ready !== 0) begin errors++; $display("FAIL ready_commit: got %b want 0", wif.wr_ready); end
    @(negedge clk);
    checks++; if (count !== 8'd0 || wif.wr_ready !== 1)
      begin errors++; $display("FAIL ready_after_commit: got count=%0d rdy=%b want 0 1", count, wif.wr_ready); end
    @(negedge clk);
    wif.wr_valid = 1'b0;
    m_pend[0] = 8'd6;
    wait_count(8'd10);
    exp_b = (8'd10 < m_act[0]);
    checks++; if (pwm[0] !== exp_b) begin errors++; $display("FAIL late_write_deferred: got %b want %b", pwm[0], exp_b); end
    measure(0, hi, len, w);
    checks++; if (hi !== w) begin errors++; $display("FAIL late_write_applied: got %0d want %0d", hi, w); end
`ifndef SLEW_LIMIT_EN
    checks++; if (hi !== 6) begin errors++; $display("FAIL late_write_abs: got %0d want 6", hi); end
`endif
  endtask

  task automatic test_period;
    int hi, len, w;
    bit acc;
    @(negedge clk);
    wait_count(8'd2);
    do_write(1'b0, 8'd12, acc);
    period = 8'd10;
    wait_count(8'd19);
    checks++; if (count !== 8'd19) begin errors++; $display("FAIL old_period_kept: got %0d want 19", count); end
    measure(0, hi, len, w);
    checks++; if (len !== 10) begin errors++; $display("FAIL period10_len: got %0d want 10", len); end
    checks++; if (hi !== ((w > 10) ? 10 : w)) begin errors++; $display("FAIL period10_hi0: got %0d want %0d", hi, (w > 10) ? 10 : w); end
    measure(1, hi, len, w);
    checks++; if (hi !== 10) begin errors++; $display("FAIL pw_eq_period: got %0d want 10", hi); end
    period = 8'd1;
    @(negedge clk);
    measure(0, hi, len, w);
    checks++; if (len !== 2 || hi !== 2) begin errors++; $display("FAIL period1: got len=%0d hi=%0d want 2 2", len, hi); end
    period = 8'd20;
    @(negedge clk);
    measure(0, hi, len, w);
    checks++; if (len !== 20) begin errors++; $display("FAIL period_restore: got %0d want 20", len); end
  endtask

  task automatic test_slew;
    int hi, len, w, h1, h2;
    bit acc;
    @(negedge clk);
    do_write(1'b0, 8'd8, acc);
    measure(0, hi, len, w);
    measure(0, hi, len, w);
    checks++; if (hi !== 8) begin errors++; $display("FAIL slew_base: got %0d want 8", hi); end
    @(negedge clk);
    do_write(1'b0, 8'd12, acc);
    measure(0, h1, len, w);
    measure(0, h2, len, w);
`ifdef SLEW_LIMIT_EN
    checks++; if (h1 !== 10 || h2 !== 12) begin errors++; $display("FAIL slew_steps: got %0d,%0d want 10,12", h1, h2); end
`else
    checks++; if (h1 !== 12 || h2 !== 12) begin errors++; $display("FAIL direct_commit: got %0d,%0d want 12,12", h1, h2); end
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    clr_n = 1'b0; en = 1'b0; period = 8'd20;
    wif.wr_valid = 1'b0;  wif.wr_ch = 1'b0;  wif.wr_pw = 8'd0;
    wif3.wr_valid = 1'b0; wif3.wr_ch = 2'd0; wif3.wr_pw = 8'd0;
    m_pend[0] = 8'd8; m_pend[1] = 8'd8;
    test_reset;
    test_basic;
    test_write_defer;
    test_clamp;
    test_ready_commit;
    test_period;
    test_slew;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
